// File: rtl/smoothing_window_gen.sv
// rtl/smoothing_window_gen.sv - 3x3 raster window generator for a smoothing filter
// Two line buffers plus a 3x3 shift register; one registered window per interior pixel.
module smoothing_window_gen #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  pixel_in,
  input  logic        in_valid,
  input  logic        sof,
  output logic        in_ready,
  output logic [71:0] window,
  output logic        win_valid,
  input  logic        win_ready,
  output logic        eof,
  output logic        frame_err
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] col_q, col_d, cur_col;
  logic [RW-1:0] row_q, row_d, cur_row;
  logic [7:0]    line1_q [IMG_W];
  logic [7:0]    line2_q [IMG_W];
  logic [7:0]    shreg_q [9];
  logic          win_valid_q, win_valid_d;
  logic          eof_q, eof_d;
  logic          frame_err_q, frame_err_d;
  logic          accept, take, gen, last_px;

  assign in_ready  = !win_valid_q || win_ready;
  assign accept    = in_valid && in_ready;
  // In IDLE only a sof pixel joins a frame; others are accepted and dropped.
  assign take      = accept && (sof || state_q != ST_IDLE);
  assign last_px   = (col_q == COL_LAST) && (row_q == ROW_LAST);
  assign gen       = accept && !sof && (state_q == ST_RUN) && (col_q >= CW'(2));
  assign win_valid = win_valid_q;
  assign eof       = eof_q;
  assign frame_err = frame_err_q;

  always_comb begin
    for (int k = 0; k < 9; k++) begin
      window[8*k +: 8] = shreg_q[k];
    end
  end

  always_comb begin
    cur_col = sof ? '0 : col_q;
    cur_row = sof ? '0 : row_q;
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    if (take) begin
      if (cur_col == COL_LAST) begin
        col_d = '0;
        row_d = (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
      end else begin
        col_d = cur_col + 1'b1;
        row_d = cur_row;
      end
      if (sof) begin
        state_d = ST_FILL;
      end else if (state_q == ST_FILL && row_q == RW'(2) && col_q == '0) begin
        state_d = ST_RUN;
      end else if (state_q == ST_RUN && last_px) begin
        state_d = ST_IDLE;
      end
    end
  end

  always_comb begin
    win_valid_d = win_valid_q && !win_ready;
    eof_d       = eof_q && win_valid_d;
    if (gen) begin
      win_valid_d = 1'b1;
      eof_d       = last_px;
    end
    frame_err_d = accept && sof && (state_q != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      win_valid_q <= 1'b0;
      eof_q       <= 1'b0;
      frame_err_q <= 1'b0;
      for (int k = 0; k < 9; k++) begin
        shreg_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      win_valid_q <= win_valid_d;
      eof_q       <= eof_d;
      frame_err_q <= frame_err_d;
      // Shifting only on take keeps the window frozen while the output is stalled.
      if (take) begin
        for (int r = 0; r < 3; r++) begin
          shreg_q[3*r]     <= shreg_q[3*r+1];
          shreg_q[3*r + 1] <= shreg_q[3*r+2];
        end
        shreg_q[2] <= line2_q[cur_col];
        shreg_q[5] <= line1_q[cur_col];
        shreg_q[8] <= pixel_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (take) begin
      line2_q[cur_col] <= line1_q[cur_col];
      line1_q[cur_col] <= pixel_in;
    end
  end

endmodule

// File: tb/tb_smoothing_window_gen.sv
// tb/tb_smoothing_window_gen.sv - bench for smoothing_window_gen (4x4 frames)
`timescale 1ns/1ps
module tb_smoothing_window_gen;
  localparam int W = 4;
  localparam int H = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  pixel_in;
  logic        in_valid, sof, in_ready;
  logic [71:0] window;
  logic        win_valid, win_ready, eof, frame_err;

  always #5 clk = ~clk;

  smoothing_window_gen #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .pixel_in(pixel_in), .in_valid(in_valid), .sof(sof),
    .in_ready(in_ready), .window(window), .win_valid(win_valid),
    .win_ready(win_ready), .eof(eof), .frame_err(frame_err)
  );

  typedef struct packed {
    logic       v;
    logic [7:0] px;
    logic       s;
    logic       wr;
    logic       e_wv;
    logic       e_eof;
    logic [7:0] e_tl;
  } vec_t;

  vec_t tbl [20];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference: the current frame as an image plus a one-deep output slot.
  bit          m_active;
  int          m_r, m_c;
  logic [7:0]  m_img [H][W];
  bit          m_wv, m_eof, m_fe;
  logic [71:0] m_win;

  int dut_win = 0, dut_eof = 0, dut_fe = 0, dut_acc = 0;

  function automatic vec_t mk(bit v, int px, bit s, bit wr, bit wv, bit e, int tl);
    vec_t t;
    t.v = v; t.px = 8'(px); t.s = s; t.wr = wr;
    t.e_wv = wv; t.e_eof = e; t.e_tl = 8'(tl);
    return t;
  endfunction

  function automatic logic [71:0] mkwin(logic [7:0] tl);
    logic [71:0] w;
    for (int k = 0; k < 9; k++) w[8*k +: 8] = 8'(tl + 4*(k/3) + k%3);
    return w;
  endfunction

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_active = 0; m_r = 0; m_c = 0;
    m_wv = 0; m_eof = 0; m_fe = 0; m_win = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; sof = 1'b0; win_ready = 1'b0; pixel_in = '0;
    #1;
    chk("rst_win_valid", win_valid, 0);
    chk("rst_eof", eof, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_window", window, 0);
    chk("rst_in_ready", in_ready, 1);
    model_clear();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock: drive at negedge, predict, check #1 after posedge, return at negedge.
  task automatic step(input bit v, input logic [7:0] p, input bit s, input bit wr, output bit acc);
    bit nwv, neof, nfe;
    logic [71:0] nwin;
    in_valid = v; pixel_in = p; sof = s; win_ready = wr;
    #1;
    chk("in_ready", in_ready, (!m_wv || wr));
    if (win_valid && wr) begin
      dut_win++;
      if (eof) dut_eof++;
    end
    if (in_valid && in_ready) dut_acc++;
    acc  = v && (!m_wv || wr);
    nwv  = m_wv && !wr;
    neof = nwv && m_eof;
    nwin = m_win;
    nfe  = 0;
    if (acc) begin
      if (s) begin
        nfe = m_active; m_active = 1; m_r = 0; m_c = 0;
      end
      if (m_active) begin
        m_img[m_r][m_c] = p;
        if (m_r >= 2 && m_c >= 2) begin
          nwv  = 1;
          neof = (m_r == H-1) && (m_c == W-1);
          for (int k = 0; k < 9; k++) nwin[8*k +: 8] = m_img[m_r-2+k/3][m_c-2+k%3];
        end
        if (m_c == W-1) begin
          m_c = 0;
          if (m_r == H-1) begin m_r = 0; m_active = 0; end
          else m_r++;
        end else m_c++;
      end
    end
    m_wv = nwv; m_eof = neof; m_win = nwin; m_fe = nfe;
    @(posedge clk);
    #1;
    chk("win_valid", win_valid, m_wv);
    chk("eof", eof, m_eof);
    chk("frame_err", frame_err, m_fe);
    if (m_wv) chk("window", window, m_win);
    if (frame_err) dut_fe++;
    @(negedge clk);
  endtask

  task automatic send_frame(input int first, input int last);
    bit a;
    for (int p = first; p <= last; p++) step(1, 8'(p), (p == 0), 1, a);
  endtask

  initial begin
    bit acc;
    int w0, e0, f0, a0;
    rst = 1'b1; in_valid = 1'b0; pixel_in = '0; sof = 1'b0; win_ready = 1'b0;
    model_clear();

    tbl[0]  = mk(1, 7, 0, 1, 0, 0, 0);
    tbl[1]  = mk(1, 8, 0, 1, 0, 0, 0);
    tbl[2]  = mk(1, 9, 0, 1, 0, 0, 0);
    tbl[3]  = mk(1, 0, 1, 1, 0, 0, 0);
    tbl[4]  = mk(1, 1, 0, 1, 0, 0, 0);
    tbl[5]  = mk(1, 2, 0, 1, 0, 0, 0);
    tbl[6]  = mk(1, 3, 0, 1, 0, 0, 0);
    tbl[7]  = mk(1, 4, 0, 1, 0, 0, 0);
    tbl[8]  = mk(1, 5, 0, 1, 0, 0, 0);
    tbl[9]  = mk(1, 6, 0, 1, 0, 0, 0);
    tbl[10] = mk(1, 7, 0, 1, 0, 0, 0);
    tbl[11] = mk(1, 8, 0, 1, 0, 0, 0);
    tbl[12] = mk(1, 9, 0, 1, 0, 0, 0);
    tbl[13] = mk(1, 10, 0, 1, 1, 0, 0);
    tbl[14] = mk(1, 11, 0, 1, 1, 0, 1);
    tbl[15] = mk(1, 12, 0, 1, 0, 0, 0);
    tbl[16] = mk(1, 13, 0, 1, 0, 0, 0);
    tbl[17] = mk(1, 14, 0, 1, 1, 0, 4);
    tbl[18] = mk(1, 15, 0, 1, 1, 1, 5);
    tbl[19] = mk(0, 0, 0, 1, 0, 0, 0);

    @(negedge clk);
    do_reset();

    // Stray pixels in IDLE, then a clean frame.
    for (int i = 0; i < 20; i++) begin
      step(tbl[i].v, tbl[i].px, tbl[i].s, tbl[i].wr, acc);
      chk("tbl_win_valid", win_valid, tbl[i].e_wv);
      chk("tbl_eof", eof, tbl[i].e_eof);
      if (tbl[i].e_wv) chk("tbl_window", window, mkwin(tbl[i].e_tl));
    end

    // Backpressure after the first window.
    w0 = dut_win;
    send_frame(0, 10);
    for (int i = 0; i < 5; i++) begin
      step(1, 8'd11, 0, 0, acc);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_window", window, mkwin(8'd0));
    end
    for (int p = 11; p <= 15; p++) step(1, 8'(p), 0, 1, acc);
    step(0, 0, 0, 1, acc);
    chk("stall_window_count", dut_win - w0, 4);

    // Restart on the 7th pixel.
    w0 = dut_win; e0 = dut_eof; f0 = dut_fe;
    send_frame(0, 5);
    send_frame(0, 15);
    step(0, 0, 0, 1, acc);
    chk("restart_frame_err_count", dut_fe - f0, 1);
    chk("restart_window_count", dut_win - w0, 4);
    chk("restart_eof_count", dut_eof - e0, 1);

    // Reset mid-frame.
    send_frame(0, 9);
    do_reset();
    w0 = dut_win; e0 = dut_eof;
    send_frame(0, 15);
    step(0, 0, 0, 1, acc);
    chk("post_reset_window_count", dut_win - w0, 4);
    chk("post_reset_eof_count", dut_eof - e0, 1);

    // Back-to-back frames with no gap.
    w0 = dut_win; e0 = dut_eof; a0 = dut_acc;
    send_frame(0, 15);
    send_frame(0, 15);
    step(0, 0, 0, 1, acc);
    chk("b2b_accept_count", dut_acc - a0, 32);
    chk("b2b_window_count", dut_win - w0, 8);
    chk("b2b_eof_count", dut_eof - e0, 2);

    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 4) != 0, 8'($urandom), ($urandom % 24) == 0, ($urandom % 4) != 0, acc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/smoothing_window_gen.md
SMOOTHING_WINDOW_GEN -- requirements
Module: smoothing_window_gen

Interface
REQ-001 SHALL have parameter IMG_W, default 8: pixels per line, minimum 3.
REQ-002 SHALL have parameter IMG_H, default 8: lines per frame, minimum 3.
REQ-003 SHALL have port clk, input, 1: the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port pixel_in, input, 8: raster pixel, row-major order.
REQ-006 SHALL have port in_valid, input, 1: pixel_in and sof are valid.
REQ-007 SHALL have port sof, input, 1: marks pixel_in as pixel (0,0) of a frame.
REQ-008 SHALL have port in_ready, output, 1: block accepts the input this cycle.
REQ-009 SHALL have port window, output, 72: 3x3 neighbourhood; byte k = window[8k+7:8k], k = 3*r + c, r=0 top row, c=0 left column.
REQ-010 SHALL have port win_valid, output, 1: window is valid.
REQ-011 SHALL have port win_ready, input, 1: downstream smoothing stage consumes the window.
REQ-012 SHALL have port eof, output, 1: qualifies the last window of a frame; valid only with win_valid.
REQ-013 SHALL have port frame_err, output, 1: one-cycle pulse on sof received mid-frame.

Function
REQ-014 SHALL accept an input only when in_valid && in_ready; in_ready = !win_valid || win_ready (single-entry output register, no bubble under continuous flow).
REQ-015 SHALL hold window, win_valid and eof stable while win_valid && !win_ready.
REQ-016 SHALL keep column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1), advancing on each accepted pixel; col wraps to 0 and row increments at IMG_W-1.
REQ-017 SHALL keep two line buffers of IMG_W x 8 bits holding rows row-1 and row-2, read and written at index col on each accepted pixel.
REQ-018 SHALL keep a 3x3 shift register; each accepted pixel shifts in a new right column {line2[col], line1[col], pixel_in}, top to bottom.
REQ-019 SHALL implement states IDLE, FILL, RUN.
REQ-020 IDLE: accepted pixel with sof -> FILL, pixel stored as (0,0); accepted pixel without sof is discarded, no state change.
REQ-021 FILL: rows 0-1 stored, no windows; -> RUN on acceptance of pixel (2,0).
REQ-022 RUN: on acceptance of pixel (row,col) with col>=2, win_valid is asserted the next cycle with window centred on (row-1,col-1).
REQ-023 SHALL give exactly (IMG_W-2)*(IMG_H-2) windows per frame; no border windows are generated.
REQ-024 SHALL assert eof with the window produced by pixel (IMG_H-1,IMG_W-1); that acceptance returns to IDLE.
REQ-025 SHALL treat an accepted sof in FILL or RUN as a restart: pulse frame_err the next cycle, pixel taken as (0,0), state FILL; an already-registered window is still delivered unchanged.
REQ-026 SHALL ignore sof when in_valid is low.
REQ-027 Latency SHALL be one clock from acceptance of the completing pixel to win_valid.

Reset
REQ-028 SHALL, on rst high, asynchronously clear state to IDLE, col/row to 0, win_valid, eof, frame_err to 0, window to 0; in_ready = 1.
REQ-029 Line buffer contents SHALL be don't-care after reset; no window may depend on unwritten entries.
REQ-030 Reset mid-frame SHALL discard the frame; the next frame requires sof.

Verification
REQ-031 IMG_W=IMG_H=4, pixels 0..15 with sof on 0, win_ready=1 -> 4 windows: first {0,1,2,4,5,6,8,9,10} one cycle after pixel 10; last {5,6,7,9,10,11,13,14,15} with eof=1.
REQ-032 Same stream, win_ready=0 after first window -> in_ready=0, window held at {0,1,2,4,5,6,8,9,10} until win_ready=1; no pixels lost.
REQ-033 Pixels 7,8,9 with no sof while in IDLE, then the 0..15 frame -> 7,8,9 discarded; output identical to REQ-031.
REQ-034 sof asserted on the 7th pixel of a frame -> frame_err pulse one cycle; windows then correspond to the new frame only.
REQ-035 rst pulsed after pixel 9 of a frame, then a full 0..15 frame -> win_valid=0 during reset; output identical to REQ-031.
REQ-036 Two back-to-back frames, in_valid and win_ready held high -> 8 windows, eof on the 4th and 8th, no idle cycles between frames.
